// File: rtl/umi_rx_fifo.sv
// -----------------------------------------------------------------------------
// umi_rx_fifo
//
// Elastic buffer between a UMI receive port and its consumer. Holds up to
// DEPTH transactions of {data, srcaddr, dstaddr, cmd}. Both handshake outputs
// come from registered occupancy only, so no combinational path exists from
// either side's valid/ready to the other side. Live and peak occupancy are
// reported for throttling measurements.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-high reset
//   in_data      incoming UMI data            [DW-1:0]
//   in_srcaddr   incoming source address      [AW-1:0]
//   in_dstaddr   incoming destination address [AW-1:0]
//   in_cmd       incoming command             [CW-1:0]
//   in_valid     producer has a transaction
//   in_ready     buffer can accept a transaction (count != DEPTH)
//   out_data     head-of-queue data, zero when empty
//   out_srcaddr  head-of-queue source address, zero when empty
//   out_dstaddr  head-of-queue destination address, zero when empty
//   out_cmd      head-of-queue command, zero when empty
//   out_valid    head of queue is valid (count != 0)
//   out_ready    consumer accepts the head
//   count        current occupancy, 0..DEPTH
//   max_count    peak occupancy since reset
// -----------------------------------------------------------------------------
module umi_rx_fifo #(
  parameter int DW    = 256,
  parameter int AW    = 64,
  parameter int CW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DW-1:0]              in_data,
  input  logic [AW-1:0]              in_srcaddr,
  input  logic [AW-1:0]              in_dstaddr,
  input  logic [CW-1:0]              in_cmd,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DW-1:0]              out_data,
  output logic [AW-1:0]              out_srcaddr,
  output logic [AW-1:0]              out_dstaddr,
  output logic [CW-1:0]              out_cmd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] max_count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int EW   = DW + 2*AW + CW;

  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wp_q, wp_d;
  logic [PW-1:0]   rp_q, rp_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] max_q, max_d;
  logic            push, pop;
  logic [EW-1:0]   head;

  // Handshakes depend only on registered occupancy. When full, a push is
  // refused even if a pop happens in the same cycle.
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);

  assign push = in_valid  && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    max_d   = max_q;

    // DEPTH is a power of two, so the natural PW-bit overflow is the wrap.
    if (push) wp_d = wp_q + PTR_ONE;
    if (pop)  rp_d = rp_q + PTR_ONE;

    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;

    if (count_d > max_q) max_d = count_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      max_q   <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      max_q   <= max_d;
    end
  end

  // NOTE: the storage array has no reset; stale entries are unreachable
  // because count masks them, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {in_data, in_srcaddr, in_dstaddr, in_cmd};
  end

  // Gate the head with out_valid so unwritten (X) storage never leaks out.
  assign head = out_valid ? mem_q[rp_q] : '0;

  assign out_data    = head[EW-1 -: DW];
  assign out_srcaddr = head[2*AW+CW-1 -: AW];
  assign out_dstaddr = head[AW+CW-1 -: AW];
  assign out_cmd     = head[CW-1:0];

  assign count     = count_q;
  assign max_count = max_q;

endmodule

// File: tb/tb_umi_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_umi_rx_fifo
//
// Directed bench for umi_rx_fifo. A queue models the FIFO contents: entries
// are pushed when the bench drives an accepted transaction and popped and
// compared when the consumer takes the head. Handshake, occupancy and peak
// occupancy are derived from the model, not from the DUT.
// -----------------------------------------------------------------------------
module tb_umi_rx_fifo;

  localparam int DW    = 256;
  localparam int AW    = 64;
  localparam int CW    = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [CW-1:0] cmd;
  } txn_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   in_data;
  logic [AW-1:0]   in_srcaddr;
  logic [AW-1:0]   in_dstaddr;
  logic [CW-1:0]   in_cmd;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   out_data;
  logic [AW-1:0]   out_srcaddr;
  logic [AW-1:0]   out_dstaddr;
  logic [CW-1:0]   out_cmd;
  logic            out_valid;
  logic            out_ready;
  logic [CNTW-1:0] count;
  logic [CNTW-1:0] max_count;

  int   errors = 0;
  int   checks = 0;
  txn_t sb[$];
  int   max_exp = 0;

  always #5 clk = ~clk;

  umi_rx_fifo #(.DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_srcaddr (in_srcaddr),
    .in_dstaddr (in_dstaddr),
    .in_cmd     (in_cmd),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_srcaddr(out_srcaddr),
    .out_dstaddr(out_dstaddr),
    .out_cmd    (out_cmd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .max_count  (max_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input int n);
    txn_t t;
    t.data = {8{32'(n) ^ 32'h5A5A_0000}};
    t.src  = 64'h1000_0000_0000_0000 + 64'(n);
    t.dst  = 64'h2000_0000_0000_0000 + 64'(n * 3);
    t.cmd  = 32'hC000_0000 | 32'(n);
    return t;
  endfunction

  // Compare DUT state against the model between edges.
  task automatic check_state(input string where);
    check({where, ":in_ready"},  in_ready,  sb.size() != DEPTH);
    check({where, ":out_valid"}, out_valid, sb.size() != 0);
    check({where, ":count"},     count,     sb.size());
    check({where, ":max_count"}, max_count, max_exp);
    if (sb.size() == 0) begin
      check({where, ":zero_data"}, out_data, '0);
      check({where, ":zero_src"},  out_srcaddr, '0);
      check({where, ":zero_dst"},  out_dstaddr, '0);
      check({where, ":zero_cmd"},  out_cmd, '0);
    end
  endtask

  // One clock cycle: drive inputs, resolve the handshake from the model,
  // compare the popped head, advance the edge, then check the new state.
  task automatic cycle(input string where, input logic iv, input txn_t t,
                       input logic ordy);
    bit will_push, will_pop;
    txn_t exp;
    in_valid   = iv;
    in_data    = t.data;
    in_srcaddr = t.src;
    in_dstaddr = t.dst;
    in_cmd     = t.cmd;
    out_ready  = ordy;
    #1;
    will_push = iv && (sb.size() != DEPTH);
    will_pop  = ordy && (sb.size() != 0);
    if (will_pop) begin
      exp = sb.pop_front();
      check({where, ":pop_data"}, out_data,    exp.data);
      check({where, ":pop_src"},  out_srcaddr, exp.src);
      check({where, ":pop_dst"},  out_dstaddr, exp.dst);
      check({where, ":pop_cmd"},  out_cmd,     exp.cmd);
    end
    if (will_push) sb.push_back(t);
    if (sb.size() > max_exp) max_exp = sb.size();
    @(posedge clk);
    #1;
    check_state(where);
  endtask

  txn_t idle, single, t5;

  initial begin
    idle       = '0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_srcaddr = '0;
    in_dstaddr = '0;
    in_cmd     = '0;
    out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    reset = 1'b0;

    // Empty queue: out_ready alone has no effect.
    cycle("empty_rdy", 1'b0, idle, 1'b1);

    // Single transaction with fixed fields and one-cycle latency.
    single.data = 256'hA5;
    single.src  = 64'h1000;
    single.dst  = 64'h2000;
    single.cmd  = 32'h3;
    cycle("single_push", 1'b1, single, 1'b0);
    check("single:data", out_data,    256'hA5);
    check("single:src",  out_srcaddr, 256'h1000);
    check("single:dst",  out_dstaddr, 256'h2000);
    check("single:cmd",  out_cmd,     256'h3);
    cycle("single_pop", 1'b0, idle, 1'b1);

    // Fill and stall: five back-to-back pushes with the consumer stalled.
    for (int i = 1; i <= 5; i++) cycle("fill", 1'b1, mk(i), 1'b0);
    check("fill:count4", count, 256'd4);
    check("fill:max4",   max_count, 256'd4);
    t5 = mk(5);
    // Full with push and pop together: only the pop happens.
    cycle("full_pop", 1'b1, t5, 1'b1);
    check("full_pop:count3", count, 256'd3);
    // The held transaction now lands alongside the next pop.
    cycle("retry_push", 1'b1, t5, 1'b1);
    for (int i = 0; i < 3; i++) cycle("drain", 1'b0, idle, 1'b1);

    // Simultaneous push/pop at count 2 for 20 cycles; pointers wrap 5 times.
    cycle("pre2", 1'b1, mk(100), 1'b0);
    cycle("pre2", 1'b1, mk(101), 1'b0);
    for (int i = 0; i < 20; i++) cycle("stream", 1'b1, mk(200 + i), 1'b1);
    check("stream:count2", count, 256'd2);
    cycle("stream_drain", 1'b0, idle, 1'b1);
    cycle("stream_drain", 1'b0, idle, 1'b1);

    // Mid-operation reset at count 3, pulsed between edges.
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, mk(300 + i), 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    max_exp = 0;
    check_state("mid_reset");
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("post_reset");
    cycle("after_rst_push", 1'b1, mk(400), 1'b0);
    cycle("after_rst_pop",  1'b0, idle, 1'b1);
    check("after_rst:max1", max_count, 256'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
